mem_access_unit: RTL and testbench

- MEM-stage sequencer between the EX/MEM pipeline register and the byte-wide 256x8 data RAM.
- Splits each word access into four sequential byte beats and passes byte accesses through as one beat.
- Holds the pipeline with a stall output while beats are in flight, and returns the assembled read data with a one-cycle done pulse.

---
 rtl/mau_pkg.sv | 16 +
 rtl/mau_byte_lane.sv | 44 ++++
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared state encoding and request-field constants for the MEM-stage access sequencer.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIZE_BYTE  = 1'b0;
  localparam logic SIZE_WORD  = 1'b1;
  localparam logic RW_READ    = 1'b0;
  localparam logic RW_WRITE   = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/mau_byte_lane.sv
// Byte-lane datapath: big-endian write-byte selector and read shift/assembly register.
module mau_byte_lane #(
  parameter int BEATS = 4,
  parameter int KW    = 2
) (
  input  logic          clk,
  input  logic          R,
  input  logic          clear,
  input  logic          shift_en,
  input  logic [7:0]    ram_rdata,
  input  logic [KW-1:0] k,
  input  logic          size,
  input  logic [31:0]   wdata,
  output logic [31:0]   acc,
  output logic [7:0]    wbyte
);
  import mau_pkg::*;

  logic [7:0]  wbytes [BEATS];
  logic [31:0] acc_reg;

  // Beat 0 carries the most significant byte.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign wbytes[gi] = wdata[31-8*gi -: 8];
    end
  endgenerate

  assign wbyte = (size == SIZE_WORD) ? wbytes[k] : wdata[7:0];

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (shift_en) begin
      acc_reg <= {acc_reg[23:0], ram_rdata};
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: splits word accesses into four byte beats and stalls the pipeline.
// Optional MAU_ALIGN_CHECK_EN adds align_err and skips RAM beats for misaligned words.
module mem_access_unit #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              R,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       rdata,
  output logic              done,
`ifdef MAU_ALIGN_CHECK_EN
  output logic              align_err,
`endif
  output logic              stall
);
  import mau_pkg::*;

  localparam int KW = $clog2(WORD_BYTES);

  state_t            state_reg, state_next;
  logic [KW-1:0]     k_reg, k_next;
  logic              rw_reg, size_reg, err_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [31:0]       wdata_reg;
  logic              accept, misalign, last_beat;
  logic [31:0]       acc;
  logic [7:0]        lane_wbyte;

  assign accept = (state_reg == IDLE) && req_valid;

`ifdef MAU_ALIGN_CHECK_EN
  assign misalign  = (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
  assign align_err = (state_reg == DONE) && err_reg;
`else
  assign misalign  = 1'b0;
`endif

  assign last_beat = (size_reg == SIZE_BYTE) || (k_reg == KW'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      rw_reg    <= RW_READ;
      size_reg  <= SIZE_BYTE;
      err_reg   <= 1'b0;
      base_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (accept) begin
        rw_reg    <= req_rw;
        size_reg  <= req_size;
        err_reg   <= misalign;
        wdata_reg <= req_wdata;
        // Word accesses always start on the aligned base.
        base_reg  <= (req_size == SIZE_WORD) ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    stall      = 1'b0;
    ram_en     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        stall = req_valid & R;
        if (req_valid) begin
          k_next     = '0;
          state_next = misalign ? DONE : XFER;
        end
      end
      XFER: begin
        ram_en = 1'b1;
        stall  = 1'b1;
        if (last_beat) begin
          state_next = DONE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mau_byte_lane #(
    .BEATS (WORD_BYTES),
    .KW    (KW)
  ) u_lane (
    .clk       (clk),
    .R         (R),
    .clear     (accept),
    .shift_en  (ram_en && (rw_reg == RW_READ)),
    .ram_rdata (ram_rdata),
    .k         (k_reg),
    .size      (size_reg),
    .wdata     (wdata_reg),
    .acc       (acc),
    .wbyte     (lane_wbyte)
  );

  assign ram_rw    = ram_en & rw_reg;
  assign ram_addr  = ram_en ? (base_reg + ADDR_W'(k_reg)) : '0;
  assign ram_wdata = (ram_en && (rw_reg == RW_WRITE)) ? lane_wbyte : 8'h00;

  always_comb begin
    rdata = '0;
    if (done && (rw_reg == RW_READ) && !err_reg) begin
      rdata = (size_reg == SIZE_WORD) ? acc : {24'b0, acc[7:0]};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected beats/completions, a monitor pops them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        req_valid = 1'b0, req_rw = 1'b0, req_size = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        ram_en, ram_rw, done, stall;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic [31:0] rdata;
`ifdef MAU_ALIGN_CHECK_EN
  logic        align_err;
`endif

  logic [7:0] mem [256];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] addr; logic rw; logic [7:0] wdata; } beat_t;
  typedef struct { logic [31:0] rdata; int cyc; logic err; } done_t;
  beat_t bq[$];
  done_t dq[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk       (clk),
    .R         (R),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ram_en    (ram_en),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rdata     (rdata),
    .done      (done),
`ifdef MAU_ALIGN_CHECK_EN
    .align_err (align_err),
`endif
    .stall     (stall)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en && ram_rw) mem[ram_addr] <= ram_wdata;
  end

  // Monitor: compares every RAM beat and every done pulse against the queues.
  always @(negedge clk) begin
    if (R) begin
      if (ram_en) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d addr=%0d", cyc, ram_addr);
        end else begin
          beat_t b;
          b = bq.pop_front();
          if (ram_addr !== b.addr || ram_rw !== b.rw || (b.rw && ram_wdata !== b.wdata) || stall !== 1'b1) begin
            errors++;
            $display("FAIL beat cyc=%0d got addr=%0d rw=%b wdata=%h stall=%b want addr=%0d rw=%b wdata=%h stall=1",
                     cyc, ram_addr, ram_rw, ram_wdata, stall, b.addr, b.rw, b.wdata);
          end else begin
            $display("beat cyc=%0d addr=%0d rw=%b wdata=%h", cyc, ram_addr, ram_rw, ram_wdata);
          end
        end
      end
      if (done) begin
        logic got_err;
`ifdef MAU_ALIGN_CHECK_EN
        got_err = align_err;
`else
        got_err = 1'b0;
`endif
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d rdata=%h", cyc, rdata);
        end else begin
          done_t d;
          d = dq.pop_front();
          if (rdata !== d.rdata || cyc != d.cyc || stall !== 1'b0 || ram_en !== 1'b0 ||
              ram_addr !== 8'h00 || got_err !== d.err) begin
            errors++;
            $display("FAIL done cyc=%0d got rdata=%h stall=%b ram_en=%b err=%b want cyc=%0d rdata=%h stall=0 ram_en=0 err=%b",
                     cyc, rdata, stall, ram_en, got_err, d.cyc, d.rdata, d.err);
          end else begin
            $display("done cyc=%0d rdata=%h err=%b", cyc, rdata, got_err);
          end
        end
      end
    end
  end

  task automatic expect_op(input logic rw, input logic sz, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input int c0);
    logic [7:0] base;
    int nb;
    logic err;
    beat_t b;
    done_t d;
    err  = 1'b0;
    base = sz ? {addr[7:2], 2'b00} : addr;
    nb   = sz ? 4 : 1;
`ifdef MAU_ALIGN_CHECK_EN
    if (sz && addr[1:0] != 2'b00) begin
      nb  = 0;
      err = 1'b1;
    end
`endif
    for (int i = 0; i < nb; i++) begin
      b.addr  = base + 8'(i);
      b.rw    = rw;
      b.wdata = sz ? wd[31-8*i -: 8] : wd[7:0];
      bq.push_back(b);
    end
    d.rdata = err ? 32'h0 : exp_rd;
    d.cyc   = c0 + 1 + nb;
    d.err   = err;
    dq.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((bq.size() != 0 || dq.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout beats_left=%0d dones_left=%0d want 0", name, bq.size(), dq.size());
      bq.delete();
      dq.delete();
    end
  endtask

  task automatic issue(input string name, input logic rw, input logic sz, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    int c0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_rw = rw; req_size = sz; req_addr = addr; req_wdata = wd;
    c0 = cyc;
    expect_op(rw, sz, addr, wd, exp_rd, c0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_stall got=%b want=1", name, stall);
    end
    @(posedge clk);
    #1;
    // Scrambled request inputs during the transfer must be ignored.
    req_valid = 1'b0; req_rw = ~rw; req_size = ~sz; req_addr = ~addr; req_wdata = ~wd;
    wait_drain(name);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (ram_en !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 8'h00 ||
        rdata !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s got en=%b rw=%b addr=%h wdata=%h rdata=%h done=%b stall=%b want all 0",
               name, ram_en, ram_rw, ram_addr, ram_wdata, rdata, done, stall);
    end else begin
      $display("%s outputs quiet", name);
    end
  endtask

  task automatic check_mem(input logic [7:0] addr, input logic [7:0] want);
    checks++;
    if (mem[addr] !== want) begin
      errors++;
      $display("FAIL ram_contents addr=%0d got=%h want=%h", addr, mem[addr], want);
    end
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[52] = 8'h11; mem[53] = 8'h22; mem[54] = 8'h33; mem[55] = 8'h44;
    mem[56] = 8'hA5; mem[57] = 8'h3C; mem[255] = 8'h5A;

    #1;
    check_quiet("reset_state");
    repeat (2) @(posedge clk);
    #1 R = 1'b1;
    #1;
    check_quiet("idle_after_reset");

    issue("word_read_52", 1'b0, 1'b1, 8'd52, 32'h0, 32'h11223344);
    issue("byte_read_56", 1'b0, 1'b0, 8'd56, 32'h0, 32'h000000A5);
    issue("word_write_60", 1'b1, 1'b1, 8'd60, 32'hDEADBEEF, 32'h0);
    check_mem(8'd60, 8'hDE);
    check_mem(8'd61, 8'hAD);
    check_mem(8'd62, 8'hBE);
    check_mem(8'd63, 8'hEF);
    issue("byte_read_255", 1'b0, 1'b0, 8'd255, 32'h0, 32'h0000005A);
    issue("byte_write_254", 1'b1, 1'b0, 8'd254, 32'h12345677, 32'h0);
    check_mem(8'd254, 8'h77);
    check_mem(8'd255, 8'h5A);

    // Reset during beat 2 of a word read.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_rw = 1'b0; req_size = 1'b1; req_addr = 8'd52;
    c0 = cyc;
    expect_op(1'b0, 1'b1, 8'd52, 32'h0, 32'h11223344, c0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 R = 1'b0;
    #1;
    check_quiet("reset_mid_xfer");
    bq.delete();
    dq.delete();
    @(posedge clk);
    #1 R = 1'b1;
    issue("byte_read_57_after_reset", 1'b0, 1'b0, 8'd57, 32'h0, 32'h0000003C);

    // Back-to-back: req_valid held through DONE.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_rw = 1'b0; req_size = 1'b0; req_addr = 8'd57;
    c0 = cyc;
    expect_op(1'b0, 1'b0, 8'd57, 32'h0, 32'h0000003C, c0);
    expect_op(1'b0, 1'b1, 8'd52, 32'h0, 32'h11223344, c0 + 3);
    @(posedge clk);
    #1;
    req_size = 1'b1; req_addr = 8'd52;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain("back_to_back");

    issue("misaligned_word_53", 1'b0, 1'b1, 8'd53, 32'h0, 32'h11223344);
    #1;
    check_quiet("idle_at_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
